// File: rtl/binary_decoder_seq.sv
// binary_decoder_seq: registered binary-to-one-hot decoder with an optional scanning walker
// Ports: clk rising-edge clock; rst asynchronous active-high reset; en global enable (low freezes all state);
//   valid_in/i/mode present a code to accept (mode 0 decode, 1 scan); y registered one-hot result (zero = none);
//   valid_out one-cycle pulse on every y update; err last accepted code was >= NUM_OUT; busy high while scanning.
// Build option: define DECODER_SCAN_EN to include the SCAN state, the dwell counter and busy;
//   without it every accept decodes, mode is ignored and busy is tied low.
module binary_decoder_seq #(
  parameter int N       = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               valid_in,
  input  logic [N-1:0]       i,
  input  logic               mode,
  output logic [NUM_OUT-1:0] y,
  output logic               valid_out,
  output logic               err,
  output logic               busy
);
  localparam logic [N:0] LIMIT = (N+1)'(NUM_OUT);
  logic               accept;
  logic               in_range;
  logic [NUM_OUT-1:0] code_oh;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic               err_q, err_d;
  logic               vld_q, vld_d;
  assign accept   = en && valid_in;
  assign in_range = {1'b0, i} < LIMIT;
  assign code_oh  = in_range ? NUM_OUT'(1) << i : '0;
`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       step;
  // an accept on the same edge takes priority, so a due step is simply dropped
  assign step = en && !valid_in && state_q == SCAN && cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    err_d   = err_q;
    vld_d   = step;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = mode ? SCAN : HOLD;
      // an out-of-range scan start still walks, beginning from output 0
      y_d     = (mode && !in_range) ? NUM_OUT'(1) : code_oh;
      err_d   = !in_range;
      vld_d   = 1'b1;
      cnt_d   = '0;
    end else if (en && state_q == SCAN) begin
      // rotate keeps exactly one bit set and wraps NUM_OUT-1 -> 0 with no gap
      y_d   = step ? {y_q[NUM_OUT-2:0], y_q[NUM_OUT-1]} : y_q;
      cnt_d = step ? '0 : cnt_q + 8'd1;
    end
  end
  assign busy = state_q == SCAN;
`else
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic   unused_mode;
  assign unused_mode = mode;
  always_comb begin
    state_d = accept ? HOLD : state_q;
    y_d     = accept ? code_oh : y_q;
    err_d   = accept ? !in_range : err_q;
    vld_d   = accept;
  end
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef DECODER_SCAN_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
`ifdef DECODER_SCAN_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign y         = y_q;
  assign err       = err_q;
  assign valid_out = vld_q;
endmodule

// File: tb/tb_binary_decoder_seq.sv
// tb_binary_decoder_seq: random and directed checks of three decoder configurations against a position-based model
module tb_binary_decoder_seq;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif
  logic       clk;
  logic       rst;
  logic       en;
  logic       valid_in;
  logic       mode;
  logic [2:0] i;
  logic [7:0] y_a;
  logic [5:0] y_b;
  logic [7:0] y_c;
  logic [2:0] vo, er, bz;
  int n_checks = 0;
  int n_fail   = 0;
  int nout[3]  = '{8, 6, 8};
  int dwell[3] = '{1, 2, 2};
  int pos[3];
  int elapsed[3];
  bit merr[3], mscan[3], mval[3];
  binary_decoder_seq u_a (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .i(i), .mode(mode),
    .y(y_a), .valid_out(vo[0]), .err(er[0]), .busy(bz[0])
  );
  binary_decoder_seq #(.N(3), .NUM_OUT(6), .DWELL(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .i(i), .mode(mode),
    .y(y_b), .valid_out(vo[1]), .err(er[1]), .busy(bz[1])
  );
  binary_decoder_seq #(.N(3), .NUM_OUT(8), .DWELL(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .i(i), .mode(mode),
    .y(y_c), .valid_out(vo[2]), .err(er[2]), .busy(bz[2])
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pos[k] = -1; elapsed[k] = 0; merr[k] = 1'b0; mscan[k] = 1'b0; mval[k] = 1'b0;
    end
  endtask
  task automatic model_step(input bit e, input bit v, input bit md, input int code);
    for (int k = 0; k < 3; k++) begin
      mval[k] = 1'b0;
      if (e && v) begin
        mscan[k]   = SCAN_EN && md;
        merr[k]    = code >= nout[k];
        pos[k]     = code < nout[k] ? code : (mscan[k] ? 0 : -1);
        elapsed[k] = 0;
        mval[k]    = 1'b1;
      end else if (e && mscan[k]) begin
        elapsed[k]++;
        if (elapsed[k] == dwell[k]) begin
          elapsed[k] = 0;
          pos[k]     = (pos[k] + 1) % nout[k];
          mval[k]    = 1'b1;
        end
      end
    end
  endtask
  task automatic check_all();
    logic [31:0] yv [3];
    yv[0] = {24'b0, y_a};
    yv[1] = {26'b0, y_b};
    yv[2] = {24'b0, y_c};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("y%0d", k), yv[k], pos[k] < 0 ? 32'd0 : 32'd1 << pos[k]);
      check($sformatf("valid_out%0d", k), 32'(vo[k]), 32'(mval[k]));
      check($sformatf("err%0d", k), 32'(er[k]), 32'(merr[k]));
      check($sformatf("busy%0d", k), 32'(bz[k]), 32'(mscan[k]));
      check($sformatf("onehot%0d", k), 32'($countones(yv[k]) <= 1), 32'd1);
    end
  endtask
  task automatic cyc(input bit e, input bit v, input bit md, input int code);
    en = e; valid_in = v; mode = md; i = code[2:0];
    @(posedge clk);
    model_step(e, v, md, code);
    #1 check_all();
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; mode = 1'b0; i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 8; c++) cyc(1, 1, 0, c);
    check("dec7_lit", {24'b0, y_a}, 32'h80);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 6);
    check("oor_err_lit", 32'(er[1]), 32'd1);
    check("oor_y_lit", {26'b0, y_b}, 32'd0);
    cyc(1, 1, 0, 2);
    check("dec2_lit", {26'b0, y_b}, 32'h4);
    cyc(1, 1, 1, 6);
    repeat (3) cyc(1, 0, 0, 0);
    for (int c = 0; c < 5; c++) cyc(0, c[0], 1, 3);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 7);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 2);
    cyc(1, 1, 0, 4);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 5);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 5);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 7);
    cyc(1, 0, 0, 0);
    async_reset();
    cyc(1, 1, 0, 3);
    check("post_rst_lit", {24'b0, y_a}, 32'h8);
    repeat (3) cyc(1, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/binary_decoder_seq.md
BINARY_DECODER_SEQ -- requirements
Module: binary_decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the binary code width.
REQ-002 The block SHALL have parameter NUM_OUT, default 8, giving the one-hot output count; legal range 2..2**N.
REQ-003 The block SHALL have parameter DWELL, default 1, giving the number of cycles per scan step; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: global enable; when low, all state holds.
REQ-007 The block SHALL have port valid_in, input, 1 bit: i and mode are presented this cycle.
REQ-008 The block SHALL have port i, input, N bits: binary code (decode value or scan start index).
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = decode, 1 = scan; sampled only with valid_in.
REQ-010 The block SHALL have port y, output, NUM_OUT bits: registered one-hot output; all-zero means none.
REQ-011 The block SHALL have port valid_out, output, 1 bit: one-cycle pulse on every y update.
REQ-012 The block SHALL have port err, output, 1 bit: the last accepted code was >= NUM_OUT.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state SCAN.

Function
REQ-014 An input SHALL be accepted on a rising clk edge when en=1 and valid_in=1; there is no back-pressure.
REQ-015 The state machine SHALL have states IDLE, HOLD and SCAN; reset enters IDLE.
REQ-016 Decode accept (mode=0) from any state: on the next edge, y = one-hot(i) with bit i set, err=0, valid_out=1, state -> HOLD; latency is 1 cycle.
REQ-017 Decode accept with i >= NUM_OUT: y=0, err=1, valid_out=1, state -> HOLD.
REQ-018 In HOLD, y and err SHALL hold until the next accept; valid_out=0.
REQ-019 Scan accept (mode=1): y = one-hot(i) and state -> SCAN, with err=0; if i >= NUM_OUT, then y = one-hot(0) and err=1.
REQ-020 In SCAN, after every DWELL enabled cycles the single set bit SHALL advance by one position, with valid_out=1 for that cycle.
REQ-021 The scan index SHALL wrap from NUM_OUT-1 to 0 with no gap cycle.
REQ-022 A decode accept during SCAN SHALL exit to HOLD with the decode result, and the dwell counter SHALL clear.
REQ-023 A scan accept during SCAN SHALL reload the start index and restart the dwell count.
REQ-024 An accept on the same edge that a scan step falls due SHALL win; the step is discarded.
REQ-025 When en=0, y, err, the state and the dwell counter SHALL freeze; valid_out=0; valid_in SHALL be ignored.
REQ-026 y SHALL never have more than one bit set in any cycle.

Reset
REQ-027 Asserting rst SHALL immediately force y=0, valid_out=0, err=0, busy=0, state IDLE and dwell counter 0, independent of clk and including mid-scan.
REQ-028 After rst deasserts, the first accept SHALL behave per REQ-016/REQ-019 with no extra latency.

Configuration
REQ-029 The macro DECODER_SCAN_EN SHALL compile in the SCAN state, the dwell counter and the busy logic.
REQ-030 Without DECODER_SCAN_EN, mode SHALL be ignored and every accept treated as decode; busy SHALL be tied 0; no SCAN state SHALL exist.

Verification
REQ-031 Defaults; decode accepts of i=0..7 back-to-back -> y = 00000001..10000000 each one cycle later, with valid_out high for 8 cycles and err=0.
REQ-032 N=3, NUM_OUT=6; decode i=6 then i=2 -> y=000000 with err=1, then y=000100 with err=0.
REQ-033 DECODER_SCAN_EN, DWELL=2; scan start i=6 -> y=01000000 (2 cycles), 10000000 (2 cycles), 00000001, busy=1 throughout.
REQ-034 Mid-scan en=0 for 5 cycles -> y frozen and valid_out=0; resume -> the remaining dwell completes, then the next step.
REQ-035 Assert rst asynchronously mid-scan, between edges -> y=0 and busy=0 before the next edge; a decode of i=3 afterwards -> y=00001000 after 1 cycle.
REQ-036 Without DECODER_SCAN_EN, scan accept of i=5 -> y=00100000, state HOLD, busy=0, and no further steps.
